// File: rtl/hsr_axi_csr_bridge_if.sv
// AXI4 slave and CSR request/ack bundle for the HSR host bridge.
// The slave modport is the bridge side; the master modport is the host/register side.
interface hsr_axi_csr_bridge_if #(
    parameter int ADDR_W = 12
);
    logic [31:0]       s_axi_awaddr;
    logic [7:0]        s_axi_awlen;
    logic [2:0]        s_axi_awsize;
    logic [1:0]        s_axi_awburst;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic [2:0]        s_axi_arsize;
    logic [1:0]        s_axi_arburst;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wlast;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic              csr_req;
    logic              csr_we;
    logic [ADDR_W-1:0] csr_addr;
    logic [31:0]       csr_wdata;
    logic [3:0]        csr_be;
    logic              csr_ack;
    logic [31:0]       csr_rdata;

    modport slave (
        input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
        input  s_axi_awvalid,
        output s_axi_awready,
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        input  s_axi_arvalid,
        output s_axi_arready,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_wready,
        output s_axi_bresp, s_axi_bvalid,
        input  s_axi_bready,
        output s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        input  s_axi_rready,
        output csr_req, csr_we, csr_addr, csr_wdata, csr_be,
        input  csr_ack, csr_rdata
    );

    modport master (
        output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst,
        output s_axi_awvalid,
        input  s_axi_awready,
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst,
        output s_axi_arvalid,
        input  s_axi_arready,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_wready,
        input  s_axi_bresp, s_axi_bvalid,
        output s_axi_bready,
        input  s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
        output s_axi_rready,
        input  csr_req, csr_we, csr_addr, csr_wdata, csr_be,
        output csr_ack, csr_rdata
    );
endinterface

// File: rtl/hsr_axi_csr_bridge.sv
// AXI4 burst slave that splits host bursts into single-word CSR cycles.
// Each CSR beat has a bounded wait so a dead register target cannot stall the bus.
module hsr_axi_csr_bridge #(
    parameter int ADDR_W  = 12,
    parameter int TIMEOUT = 255
) (
    input logic                s_axi_aclk,
    input logic                s_axi_areset,
    hsr_axi_csr_bridge_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_CSR,
        WR_RESP,
        RD_CSR,
        RD_DATA
    } state_t;

    state_t            state;
    logic              prefer_wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [1:0]        burst;
    logic [7:0]        beat;
    logic              berr;
    logic              werr;
    logic [TW-1:0]     tcnt;

    logic [ADDR_W-1:0] inc_addr;
    logic [ADDR_W-1:0] wmask;
    logic [ADDR_W-1:0] nxt_addr;
    logic              last_beat;
    logic              tmo;
    logic              aw_bad;
    logic              ar_bad;
    logic              take_wr;
    logic              take_rd;

    function automatic logic burst_bad(
        input logic [31:0] a,
        input logic [7:0]  l,
        input logic [2:0]  s,
        input logic [1:0]  b
    );
        logic wrap_ok;
        wrap_ok = (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd15);
        return (a[31:ADDR_W] != '0) || (s != 3'd2) || (b == 2'b11) ||
               ((b == 2'b10) && !wrap_ok);
    endfunction

    // WRAP lengths are 2/4/8/16 beats, so the window mask is {len,2'b11}
    always_comb begin
        inc_addr = addr + ADDR_W'(4);
        wmask    = ADDR_W'({len[3:0], 2'b11});
        nxt_addr = addr;
        unique case (burst)
            2'b01:   nxt_addr = inc_addr;
            2'b10:   nxt_addr = (addr & ~wmask) | (inc_addr & wmask);
            default: nxt_addr = addr;
        endcase
    end

    assign last_beat = (beat == len);
    assign tmo       = (tcnt == TW'(TIMEOUT));
    assign aw_bad    = burst_bad(bus.s_axi_awaddr, bus.s_axi_awlen,
                                 bus.s_axi_awsize, bus.s_axi_awburst);
    assign ar_bad    = burst_bad(bus.s_axi_araddr, bus.s_axi_arlen,
                                 bus.s_axi_arsize, bus.s_axi_arburst);
    assign take_wr   = bus.s_axi_awvalid && (!bus.s_axi_arvalid || prefer_wr);
    assign take_rd   = bus.s_axi_arvalid && (!bus.s_axi_awvalid || !prefer_wr);

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            state             <= IDLE;
            prefer_wr         <= 1'b1;
            addr              <= '0;
            len               <= '0;
            burst             <= '0;
            beat              <= '0;
            berr              <= 1'b0;
            werr              <= 1'b0;
            tcnt              <= '0;
            bus.s_axi_awready <= 1'b0;
            bus.s_axi_arready <= 1'b0;
            bus.s_axi_wready  <= 1'b0;
            bus.s_axi_bresp   <= 2'b00;
            bus.s_axi_bvalid  <= 1'b0;
            bus.s_axi_rdata   <= 32'd0;
            bus.s_axi_rresp   <= 2'b00;
            bus.s_axi_rlast   <= 1'b0;
            bus.s_axi_rvalid  <= 1'b0;
            bus.csr_req       <= 1'b0;
            bus.csr_we        <= 1'b0;
            bus.csr_addr      <= '0;
            bus.csr_wdata     <= 32'd0;
            bus.csr_be        <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.s_axi_awready) begin
                        bus.s_axi_awready <= 1'b0;
                        addr              <= bus.s_axi_awaddr[ADDR_W-1:0];
                        len               <= bus.s_axi_awlen;
                        burst             <= bus.s_axi_awburst;
                        berr              <= aw_bad;
                        werr              <= aw_bad;
                        beat              <= '0;
                        bus.s_axi_wready  <= 1'b1;
                        state             <= WR_DATA;
                    end else if (bus.s_axi_arready) begin
                        bus.s_axi_arready <= 1'b0;
                        addr              <= bus.s_axi_araddr[ADDR_W-1:0];
                        len               <= bus.s_axi_arlen;
                        burst             <= bus.s_axi_arburst;
                        berr              <= ar_bad;
                        beat              <= '0;
                        if (ar_bad) begin
                            bus.s_axi_rvalid <= 1'b1;
                            bus.s_axi_rdata  <= 32'd0;
                            bus.s_axi_rresp  <= 2'b10;
                            bus.s_axi_rlast  <= (bus.s_axi_arlen == 8'd0);
                            state            <= RD_DATA;
                        end else begin
                            bus.csr_req  <= 1'b1;
                            bus.csr_we   <= 1'b0;
                            bus.csr_be   <= 4'hF;
                            bus.csr_addr <= {bus.s_axi_araddr[ADDR_W-1:2], 2'b00};
                            tcnt         <= TW'(1);
                            state        <= RD_CSR;
                        end
                    end else begin
                        bus.s_axi_awready <= take_wr;
                        bus.s_axi_arready <= take_rd;
                        if (take_wr || take_rd) begin
                            prefer_wr <= !take_wr;
                        end
                    end
                end

                WR_DATA: begin
                    if (bus.s_axi_wvalid) begin
                        if (berr) begin
                            if (last_beat) begin
                                bus.s_axi_wready <= 1'b0;
                                bus.s_axi_bvalid <= 1'b1;
                                bus.s_axi_bresp  <= 2'b10;
                                state            <= WR_RESP;
                            end else begin
                                beat <= beat + 8'd1;
                                addr <= nxt_addr;
                            end
                        end else begin
                            bus.s_axi_wready <= 1'b0;
                            bus.csr_req      <= 1'b1;
                            bus.csr_we       <= 1'b1;
                            bus.csr_addr     <= {addr[ADDR_W-1:2], 2'b00};
                            bus.csr_wdata    <= bus.s_axi_wdata;
                            bus.csr_be       <= bus.s_axi_wstrb;
                            tcnt             <= TW'(1);
                            state            <= WR_CSR;
                        end
                    end
                end

                WR_CSR: begin
                    if (bus.csr_ack || tmo) begin
                        bus.csr_req <= 1'b0;
                        bus.csr_we  <= 1'b0;
                        werr        <= werr || !bus.csr_ack;
                        if (last_beat) begin
                            bus.s_axi_bvalid <= 1'b1;
                            bus.s_axi_bresp  <= (werr || !bus.csr_ack) ? 2'b10 : 2'b00;
                            state            <= WR_RESP;
                        end else begin
                            beat             <= beat + 8'd1;
                            addr             <= nxt_addr;
                            bus.s_axi_wready <= 1'b1;
                            state            <= WR_DATA;
                        end
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                WR_RESP: begin
                    if (bus.s_axi_bready) begin
                        bus.s_axi_bvalid <= 1'b0;
                        bus.s_axi_bresp  <= 2'b00;
                        state            <= IDLE;
                    end
                end

                RD_CSR: begin
                    if (bus.csr_ack || tmo) begin
                        bus.csr_req      <= 1'b0;
                        bus.s_axi_rvalid <= 1'b1;
                        bus.s_axi_rdata  <= bus.csr_ack ? bus.csr_rdata : 32'd0;
                        bus.s_axi_rresp  <= bus.csr_ack ? 2'b00 : 2'b10;
                        bus.s_axi_rlast  <= last_beat;
                        state            <= RD_DATA;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

                RD_DATA: begin
                    if (bus.s_axi_rready) begin
                        if (last_beat) begin
                            bus.s_axi_rvalid <= 1'b0;
                            bus.s_axi_rlast  <= 1'b0;
                            bus.s_axi_rdata  <= 32'd0;
                            bus.s_axi_rresp  <= 2'b00;
                            state            <= IDLE;
                        end else begin
                            beat <= beat + 8'd1;
                            addr <= nxt_addr;
                            // a bad burst never touches the CSR bus, beats stream out as errors
                            if (berr) begin
                                bus.s_axi_rdata <= 32'd0;
                                bus.s_axi_rresp <= 2'b10;
                                bus.s_axi_rlast <= ((beat + 8'd1) == len);
                            end else begin
                                bus.s_axi_rvalid <= 1'b0;
                                bus.s_axi_rlast  <= 1'b0;
                                bus.csr_req      <= 1'b1;
                                bus.csr_we       <= 1'b0;
                                bus.csr_be       <= 4'hF;
                                bus.csr_addr     <= {nxt_addr[ADDR_W-1:2], 2'b00};
                                tcnt             <= TW'(1);
                                state            <= RD_CSR;
                            end
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hsr_axi_csr_bridge.sv
// Directed bench for hsr_axi_csr_bridge against a transaction-level model.
// A CSR responder acks after a programmable delay; one monitor compares all traffic.
module tb_hsr_axi_csr_bridge;
    localparam int TO  = 15;
    localparam int LIM = 400;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hsr_axi_csr_bridge_if #(.ADDR_W(12)) bus ();

    hsr_axi_csr_bridge #(.ADDR_W(12), .TIMEOUT(TO)) dut (
        .s_axi_aclk  (clk),
        .s_axi_areset(rst),
        .bus         (bus)
    );

    typedef struct {
        bit          we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          dur;
    } csr_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        bit          last;
    } r_exp_t;

    int checks = 0;
    int errors = 0;
    csr_exp_t    cq[$];
    r_exp_t      rq[$];
    logic [1:0]  bq[$];
    bit          gq[$];
    logic [11:0] addr_log[$];
    int last_len, wbeats, rlast_cnt, rv_cnt, csr_rises, r_acc;
    int ack_dly;
    bit spurious;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic logic [31:0] rdval(input logic [11:0] a);
        return {20'hC5A5C, a};
    endfunction

    function automatic logic [3:0] strb_of(input int i);
        logic [3:0] f;
        f = 4'hF;
        return f >> (i % 4);
    endfunction

    function automatic int beat_addr(input int start, input int len, input logic [1:0] bt, input int i);
        int win, base;
        case (bt)
            2'b00: return start;
            2'b10: begin
                win  = (len + 1) * 4;
                base = (start / win) * win;
                return base + ((start - base) + 4 * i) % win;
            end
            default: return (start + 4 * i) % 4096;
        endcase
    endfunction

    task automatic model(input bit wr, input logic [31:0] addr, input int len,
                         input logic [2:0] size, input logic [1:0] bt, input logic [31:0] wbase);
        bit bad, ok, any;
        int a;
        csr_exp_t c;
        r_exp_t r;
        bad = (addr[31:12] != 0) || (size != 3'd2) || (bt == 2'b11) ||
              (bt == 2'b10 && !(len == 1 || len == 3 || len == 7 || len == 15));
        ok  = !bad && ack_dly >= 1 && ack_dly <= TO;
        any = bad;
        gq.push_back(wr);
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(int'(addr[11:0]), len, bt, i);
            if (!bad) begin
                c.we    = wr;
                c.addr  = 12'(a);
                c.wdata = wbase + 32'(i);
                c.be    = wr ? strb_of(i) : 4'hF;
                c.dur   = ok ? ack_dly : TO;
                cq.push_back(c);
            end
            if (!ok) any = 1'b1;
            if (!wr) begin
                r.data = ok ? rdval(12'(a)) : 32'd0;
                r.resp = ok ? 2'b00 : 2'b10;
                r.last = (i == len);
                rq.push_back(r);
            end
        end
        if (wr) bq.push_back(any ? 2'b10 : 2'b00);
    endtask

    // CSR target: acks on the ack_dly-th cycle of a request (0 = never)
    int rcnt = 0;
    initial begin
        bus.csr_ack   = 1'b0;
        bus.csr_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (bus.csr_req && !rst) begin
                rcnt++;
                if (ack_dly != 0 && rcnt == ack_dly) begin
                    bus.csr_ack   = 1'b1;
                    bus.csr_rdata = bus.csr_we ? 32'd0 : rdval(bus.csr_addr);
                end else begin
                    bus.csr_ack   = 1'b0;
                    bus.csr_rdata = 32'hDEAD_BEEF;
                end
            end else begin
                rcnt          = 0;
                bus.csr_ack   = spurious;
                bus.csr_rdata = 32'hDEAD_BEEF;
            end
        end
    end

    logic     req_prev, aw_prev, ar_prev, r_hold;
    logic [34:0] r_held;
    csr_exp_t cur;
    r_exp_t   mr;
    int       req_len;

    always @(negedge clk) begin
        if (rst) begin
            req_prev = 1'b0;
            aw_prev  = 1'b0;
            ar_prev  = 1'b0;
            r_hold   = 1'b0;
        end else begin
            if (bus.csr_req) begin
                if (!req_prev) begin
                    csr_rises++;
                    addr_log.push_back(bus.csr_addr);
                    req_len = 1;
                    if (cq.size() == 0) begin
                        fail("csr_unexpected");
                        cur.dur = -1;
                    end else begin
                        cur = cq.pop_front();
                        chk("csr_we", bus.csr_we, cur.we);
                        chk("csr_addr", bus.csr_addr, cur.addr);
                        chk("csr_be", bus.csr_be, cur.be);
                        if (cur.we) chk("csr_wdata", bus.csr_wdata, cur.wdata);
                    end
                end else begin
                    req_len++;
                end
            end else if (req_prev) begin
                last_len = req_len;
                chk("csr_req_cycles", req_len, cur.dur);
            end
            req_prev = bus.csr_req;

            if (bus.s_axi_awready || bus.s_axi_arready) begin
                if ((bus.s_axi_awready && aw_prev) || (bus.s_axi_arready && ar_prev) ||
                    (bus.s_axi_awready && bus.s_axi_arready))
                    fail("ready_pulse");
                else if (gq.size() == 0)
                    fail("grant_unexpected");
                else
                    chk("grant_kind", bus.s_axi_awready, gq.pop_front());
            end
            aw_prev = bus.s_axi_awready;
            ar_prev = bus.s_axi_arready;

            if (bus.s_axi_wvalid && bus.s_axi_wready) wbeats++;

            if (bus.s_axi_rvalid) begin
                rv_cnt++;
                if (r_hold)
                    chk("r_stable", {bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast}, r_held);
                if (bus.s_axi_rready) begin
                    r_hold = 1'b0;
                    r_acc++;
                    if (bus.s_axi_rlast) rlast_cnt++;
                    if (rq.size() == 0) begin
                        fail("r_unexpected");
                    end else begin
                        mr = rq.pop_front();
                        chk("rdata", bus.s_axi_rdata, mr.data);
                        chk("rresp", bus.s_axi_rresp, mr.resp);
                        chk("rlast", bus.s_axi_rlast, mr.last);
                    end
                end else begin
                    r_hold = 1'b1;
                    r_held = {bus.s_axi_rdata, bus.s_axi_rresp, bus.s_axi_rlast};
                end
            end else begin
                r_hold = 1'b0;
            end

            if (bus.s_axi_bvalid && bus.s_axi_bready) begin
                if (bq.size() == 0) fail("b_unexpected");
                else chk("bresp", bus.s_axi_bresp, bq.pop_front());
            end
        end
    end

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] bt, input logic [31:0] wbase);
        int n;
        @(posedge clk);
        #1;
        bus.s_axi_awaddr  = addr;
        bus.s_axi_awlen   = 8'(len);
        bus.s_axi_awsize  = size;
        bus.s_axi_awburst = bt;
        bus.s_axi_awvalid = 1'b1;
        for (n = 0; n < LIM; n++) begin
            @(negedge clk);
            if (bus.s_axi_awready) break;
        end
        if (n == LIM) fail("aw_wait");
        @(posedge clk);
        #1 bus.s_axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            bus.s_axi_wdata  = wbase + 32'(i);
            bus.s_axi_wstrb  = strb_of(i);
            bus.s_axi_wlast  = (i == len);
            bus.s_axi_wvalid = 1'b1;
            for (n = 0; n < LIM; n++) begin
                @(negedge clk);
                if (bus.s_axi_wready) break;
            end
            if (n == LIM) fail("w_wait");
            @(posedge clk);
            #1;
        end
        bus.s_axi_wvalid = 1'b0;
        bus.s_axi_wlast  = 1'b0;
        bus.s_axi_bready = 1'b1;
        for (n = 0; n < LIM; n++) begin
            @(negedge clk);
            if (bus.s_axi_bvalid) break;
        end
        if (n == LIM) fail("b_wait");
        @(posedge clk);
        #1 bus.s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] bt, input bit stall);
        int n;
        bit got;
        @(posedge clk);
        #1;
        bus.s_axi_araddr  = addr;
        bus.s_axi_arlen   = 8'(len);
        bus.s_axi_arsize  = size;
        bus.s_axi_arburst = bt;
        bus.s_axi_arvalid = 1'b1;
        for (n = 0; n < LIM; n++) begin
            @(negedge clk);
            if (bus.s_axi_arready) break;
        end
        if (n == LIM) fail("ar_wait");
        @(posedge clk);
        #1;
        bus.s_axi_arvalid = 1'b0;
        bus.s_axi_rready  = !stall;
        got = 1'b0;
        for (n = 0; n < LIM; n++) begin
            @(negedge clk);
            if (bus.s_axi_rvalid && bus.s_axi_rready && bus.s_axi_rlast) got = 1'b1;
            @(posedge clk);
            #1;
            if (got) break;
            if (stall) bus.s_axi_rready = !bus.s_axi_rready;
        end
        if (!got) fail("rlast_wait");
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n0, c0, w0, l0, v0;
        logic [11:0] exp2[4];
        logic [11:0] exp3[4];
        exp2 = '{12'h020, 12'h024, 12'h028, 12'h02C};
        exp3 = '{12'h038, 12'h03C, 12'h030, 12'h034};
        rst = 1'b1;
        ack_dly = 1;
        spurious = 1'b0;
        bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
        bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
        bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0;
        bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0;
        bus.s_axi_wvalid = 1'b0; bus.s_axi_bready = 1'b0; bus.s_axi_rready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid,
             bus.s_axi_bresp, bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rlast,
             bus.s_axi_rdata, bus.csr_req, bus.csr_we, bus.csr_addr, bus.csr_wdata,
             bus.csr_be}, 128'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // single write, ack on the second request cycle
        ack_dly = 2;
        model(1'b1, 32'h10, 0, 3'd2, 2'b01, 32'hA5A5_0001);
        axi_write(32'h10, 0, 3'd2, 2'b01, 32'hA5A5_0001);
        chk("t1_addr_lit", addr_log[addr_log.size() - 1], 12'h010);
        chk("t1_len_lit", last_len, 2);

        // INCR read with rready toggling
        ack_dly = 1;
        n0 = addr_log.size();
        l0 = rlast_cnt;
        model(1'b0, 32'h20, 3, 3'd2, 2'b01, 32'd0);
        axi_read(32'h20, 3, 3'd2, 2'b01, 1'b1);
        for (int k = 0; k < 4; k++) chk("t2_addr_lit", addr_log[n0 + k], exp2[k]);
        chk("t2_rlast_lit", rlast_cnt - l0, 1);

        // WRAP reads: legal len3, then illegal len2
        n0 = addr_log.size();
        model(1'b0, 32'h38, 3, 3'd2, 2'b10, 32'd0);
        axi_read(32'h38, 3, 3'd2, 2'b10, 1'b0);
        for (int k = 0; k < 4; k++) chk("t3_addr_lit", addr_log[n0 + k], exp3[k]);
        c0 = csr_rises;
        model(1'b0, 32'h38, 2, 3'd2, 2'b10, 32'd0);
        axi_read(32'h38, 2, 3'd2, 2'b10, 1'b0);
        chk("t3_noreq_lit", csr_rises - c0, 0);

        // FIXED write with stray acks outside requests
        ack_dly = 3;
        spurious = 1'b1;
        model(1'b1, 32'h44, 2, 3'd2, 2'b00, 32'h1111_0000);
        axi_write(32'h44, 2, 3'd2, 2'b00, 32'h1111_0000);
        spurious = 1'b0;

        // simultaneous requests alternate after reset
        pulse_reset();
        ack_dly = 1;
        for (int k = 0; k < 2; k++) begin
            model(1'b1, 32'h200 + 32'(k * 16), 1, 3'd2, 2'b01, 32'h4000_0000 + 32'(k));
            model(1'b0, 32'h300 + 32'(k * 16), 1, 3'd2, 2'b01, 32'd0);
            fork
                axi_write(32'h200 + 32'(k * 16), 1, 3'd2, 2'b01, 32'h4000_0000 + 32'(k));
                axi_read(32'h300 + 32'(k * 16), 1, 3'd2, 2'b01, 1'b0);
            join
        end

        // timeouts: dead target, then ack on the final allowed cycle
        ack_dly = 0;
        model(1'b0, 32'h80, 0, 3'd2, 2'b01, 32'd0);
        axi_read(32'h80, 0, 3'd2, 2'b01, 1'b0);
        chk("t5_len_lit", last_len, 15);
        ack_dly = TO;
        model(1'b0, 32'h84, 0, 3'd2, 2'b01, 32'd0);
        axi_read(32'h84, 0, 3'd2, 2'b01, 1'b0);
        ack_dly = 0;
        model(1'b1, 32'h60, 1, 3'd2, 2'b01, 32'h7700_0000);
        axi_write(32'h60, 1, 3'd2, 2'b01, 32'h7700_0000);

        // out-of-range write address
        ack_dly = 1;
        c0 = csr_rises;
        w0 = wbeats;
        model(1'b1, 32'h0001_0000, 1, 3'd2, 2'b01, 32'h5500_0000);
        axi_write(32'h0001_0000, 1, 3'd2, 2'b01, 32'h5500_0000);
        chk("t6_noreq_lit", csr_rises - c0, 0);
        chk("t6_wbeats_lit", wbeats - w0, 2);

        // reset in the middle of a long read
        n0 = r_acc;
        model(1'b0, 32'h100, 7, 3'd2, 2'b01, 32'd0);
        @(posedge clk);
        #1;
        bus.s_axi_araddr = 32'h100; bus.s_axi_arlen = 8'd7;
        bus.s_axi_arsize = 3'd2; bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b1;
        begin
            int n;
            for (n = 0; n < LIM; n++) begin
                @(negedge clk);
                if (bus.s_axi_arready) break;
            end
            if (n == LIM) fail("t6_ar_wait");
            @(posedge clk);
            #1;
            bus.s_axi_arvalid = 1'b0;
            bus.s_axi_rready = 1'b1;
            for (n = 0; n < LIM; n++) begin
                @(negedge clk);
                if (r_acc - n0 >= 2) break;
            end
            if (n == LIM) fail("t6_beats_wait");
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("reset_async_outputs",
            {bus.s_axi_awready, bus.s_axi_arready, bus.s_axi_wready, bus.s_axi_bvalid,
             bus.s_axi_bresp, bus.s_axi_rvalid, bus.s_axi_rresp, bus.s_axi_rlast,
             bus.s_axi_rdata, bus.csr_req, bus.csr_we, bus.csr_addr, bus.csr_wdata,
             bus.csr_be}, 128'd0);
        cq.delete();
        rq.delete();
        bq.delete();
        gq.delete();
        bus.s_axi_rready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        v0 = rv_cnt;
        c0 = csr_rises;
        bus.s_axi_rready = 1'b1;
        repeat (20) @(negedge clk);
        chk("t6_no_rvalid_lit", rv_cnt - v0, 0);
        chk("t6_no_req_lit", csr_rises - c0, 0);
        bus.s_axi_rready = 1'b0;

        chk("csr_queue_empty", cq.size(), 0);
        chk("r_queue_empty", rq.size(), 0);
        chk("b_queue_empty", bq.size(), 0);
        chk("grant_queue_empty", gq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
